// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - iterative signed radix-4 Booth multiplier, one digit per clock
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset, has priority over start
//   start        request a multiply, accepted only in IDLE or DONE
//   multiplicand signed operand M, captured on the accepting edge
//   multiplier   signed operand Q, captured on the accepting edge
//   busy         high while Booth digits are being retired
//   done         one-cycle pulse, product is new and valid
//   product      signed 2*WIDTH-bit M*Q, held until the next result is written

module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // A carries two guard bits so that +/-2M never overflows the partial sum.
    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(WIDTH / 2 - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]       m_reg;
    logic [WIDTH-1:0]       q_reg;
    logic [AW-1:0]          a_reg;
    logic                   qm1;
    logic [CW-1:0]          cnt;

    logic                   accept;
    logic                   last_digit;

    logic [AW-1:0]          m_ext;
    logic [AW-1:0]          addend;
    logic [AW-1:0]          a_sum;
    logic [AW+WIDTH:0]      work_sum;
    logic [AW+WIDTH:0]      shifted;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        last_digit = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == LAST_DIGIT) begin
                    last_digit = 1'b1;
                    state_nxt  = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                // A start in the DONE cycle chains straight into the next CALC.
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Booth digit recode from {Q[1], Q[0], q-1} and one add/shift step.
    always_comb begin
        m_ext = {{2{m_reg[WIDTH-1]}}, m_reg};
        case ({q_reg[1:0], qm1})
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = {m_ext[AW-2:0], 1'b0};
            3'b100:         addend = AW'(0) - {m_ext[AW-2:0], 1'b0};
            3'b101, 3'b110: addend = AW'(0) - m_ext;
            default:        addend = '0;
        endcase
        a_sum    = a_reg + addend;
        work_sum = {a_sum, q_reg, qm1};
        // Arithmetic shift right by two: replicate the sign of the new A.
        shifted  = {{2{a_sum[AW-1]}}, work_sum[AW+WIDTH:2]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_reg   <= '0;
            a_reg   <= '0;
            q_reg   <= '0;
            qm1     <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else if (accept) begin
            m_reg <= multiplicand;
            a_reg <= '0;
            q_reg <= multiplier;
            qm1   <= 1'b0;
            cnt   <= '0;
        end else if (state == CALC) begin
            a_reg <= shifted[AW+WIDTH:WIDTH+1];
            q_reg <= shifted[WIDTH:1];
            qm1   <= shifted[0];
            cnt   <= cnt + CW'(1);
            if (last_digit) begin
                product <= shifted[2*WIDTH:1];
            end
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb/tb_booth_mult_seq.sv - self-checking bench for booth_mult_seq

module tb_booth_mult_seq;

    localparam int W = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [W-1:0]        multiplicand;
    logic [W-1:0]        multiplier;
    logic                busy;
    logic                done;
    logic [2*W-1:0]      product;

    int tests = 0;
    int fails = 0;

    logic [2*W-1:0] model_product;

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   m;
        logic [W-1:0]   q;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [2*W-1:0] ref_mul(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b);
        longint p;
        p = longint'(a) * longint'(b);
        return p[2*W-1:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after an edge; launches an operation, returns in its done cycle.
    task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] q,
                         input logic [2*W-1:0] exp, input string name);
        int  n;
        bit  busy_ok;
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        step();
        start        = 1'b0;
        multiplicand = $urandom();
        multiplier   = $urandom();
        check({name, " accept"}, {62'd0, busy, done}, 64'd2);
        check({name, " hold"}, 64'(product), 64'(model_product));
        n       = 0;
        busy_ok = 1'b1;
        while (!done && n < 20) begin
            step();
            n++;
            if (n < W / 2 && !busy) busy_ok = 1'b0;
        end
        check({name, " latency"}, 64'(n), 64'(W / 2));
        check({name, " busy"}, 64'(busy_ok), 64'd1);
        check({name, " product"}, 64'(product), 64'(exp));
        model_product = exp;
    endtask

    initial begin
        int ndone;
        int done_at;
        bit busy_late;

        vecs[0] = '{8'd3,    8'd5,    16'h000F};
        vecs[1] = '{8'd7,    8'hFD,   16'hFFEB};
        vecs[2] = '{8'hFF,   8'hFF,   16'h0001};
        vecs[3] = '{8'h80,   8'h80,   16'h4000};
        vecs[4] = '{8'h80,   8'h7F,   16'hC080};
        vecs[5] = '{8'd0,    8'hB3,   16'h0000};
        vecs[6] = '{8'h7F,   8'h7F,   16'h3F01};
        vecs[7] = '{8'h80,   8'd1,    16'hFF80};
        vecs[8] = '{8'hFB,   8'hF9,   16'h0023};
        vecs[9] = '{8'd1,    8'h80,   16'hFF80};

        rst           = 1'b1;
        start         = 1'b0;
        multiplicand  = '0;
        multiplier    = '0;
        model_product = '0;
        step();
        step();
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset product", 64'(product), 64'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].m, vecs[i].q, vecs[i].exp, $sformatf("vec%0d", i));
            step();
            check($sformatf("vec%0d after", i), {62'd0, busy, done}, 64'd0);
        end

        // start pulsed while busy must be ignored
        start        = 1'b1;
        multiplicand = 8'd2;
        multiplier   = 8'd3;
        step();
        start     = 1'b0;
        ndone     = 0;
        done_at   = -1;
        busy_late = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            step();
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = n;
            end
            if (n > W / 2 && busy) busy_late = 1'b1;
            if (n == 2) begin
                start        = 1'b1;
                multiplicand = 8'd9;
                multiplier   = 8'd9;
            end else begin
                start = 1'b0;
            end
        end
        check("ignore done count", 64'(ndone), 64'd1);
        check("ignore done time", 64'(done_at), 64'(W / 2));
        check("ignore product", 64'(product), 64'h0006);
        check("ignore busy late", 64'(busy_late), 64'd0);
        model_product = 16'h0006;

        // reset in the middle of an operation
        start        = 1'b1;
        multiplicand = 8'd10;
        multiplier   = 8'd10;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_product = '0;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        check("midrst product", 64'(product), 64'd0);
        ndone = 0;
        for (int n = 0; n < 8; n++) begin
            step();
            if (done) ndone++;
        end
        check("midrst no done", 64'(ndone), 64'd0);
        do_op(8'd4, 8'd4, 16'h0010, "post rst");
        step();
        check("post rst after", {62'd0, busy, done}, 64'd0);

        // back-to-back: second start lands in the DONE cycle
        do_op(8'd5, 8'd6, 16'h001E, "b2b first");
        do_op(8'hFE, 8'd9, 16'hFFEE, "b2b second");
        check("b2b second busy", 64'(busy), 64'd0);
        step();
        check("b2b after", {62'd0, busy, done}, 64'd0);

        // randomized operands, gaps and back-to-back chaining
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] rm;
            logic [W-1:0] rq;
            int gap;
            rm = W'($urandom());
            rq = W'($urandom());
            do_op(rm, rq, ref_mul(rm, rq), $sformatf("rand%0d", i));
            if ($urandom_range(0, 2) != 0) begin
                gap = $urandom_range(1, 3);
                step();
                check($sformatf("rand%0d single done", i), 64'(done), 64'd0);
                for (int g = 1; g < gap; g++) step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
